// File: rtl/score_keeper_if.sv
// Interface bundling the score keeper's game-control inputs and score/serve outputs.
// master drives the misses, ticks and start; slave is the score keeper itself.
interface score_keeper_if;
  logic       frame_tick;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic       serve;
  logic       serve_dir;
  logic       playing;
  logic       game_over;
  logic       winner;

  modport master (
    output frame_tick, start, miss_left, miss_right,
    input  player1_score, player2_score, serve, serve_dir, playing, game_over, winner
  );

  modport slave (
    input  frame_tick, start, miss_left, miss_right,
    output player1_score, player2_score, serve, serve_dir, playing, game_over, winner
  );
endinterface

// File: rtl/score_keeper.sv
// Pong match-score state machine: tracks points, paces serves on frame ticks and
// reports game-over with the winning player. All outputs come straight from registers.
module score_keeper #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input logic           clk,
  input logic           rst,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPlay, StPointPause, StGameOver} state_e;

  localparam logic [3:0] WinVal    = 4'(WIN_SCORE);
  localparam logic [7:0] PauseLast = 8'(PAUSE_FRAMES - 1);

  state_e     state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [7:0] cnt_q, cnt_d;
  logic       serve_q, serve_d;
  logic       dir_q, dir_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic [3:0] p1_inc, p2_inc;

  assign p1_inc = p1_q + 4'd1;
  assign p2_inc = p2_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    cnt_d       = cnt_q;
    serve_d     = 1'b0;
    dir_d       = dir_q;
    playing_d   = playing_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    unique case (state_q)
      StIdle: begin
        p1_d = 4'd0;
        p2_d = 4'd0;
        if (bus.start) begin
          serve_d   = 1'b1;
          dir_d     = 1'b0;
          playing_d = 1'b1;
          state_d   = StPlay;
        end
      end
      StPlay: begin
        // A simultaneous double miss is treated as a replay: nobody scores.
        if (bus.miss_left && bus.miss_right) begin
          playing_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = StPointPause;
        end else if (bus.miss_right) begin
          p1_d      = p1_inc;
          playing_d = 1'b0;
          dir_d     = 1'b1;
          cnt_d     = 8'd0;
          if (p1_inc == WinVal) begin
            game_over_d = 1'b1;
            winner_d    = 1'b0;
            state_d     = StGameOver;
          end else begin
            state_d = StPointPause;
          end
        end else if (bus.miss_left) begin
          p2_d      = p2_inc;
          playing_d = 1'b0;
          dir_d     = 1'b0;
          cnt_d     = 8'd0;
          if (p2_inc == WinVal) begin
            game_over_d = 1'b1;
            winner_d    = 1'b1;
            state_d     = StGameOver;
          end else begin
            state_d = StPointPause;
          end
        end
      end
      StPointPause: begin
        if (bus.frame_tick) begin
          if (cnt_q == PauseLast) begin
            serve_d   = 1'b1;
            playing_d = 1'b1;
            cnt_d     = 8'd0;
            state_d   = StPlay;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StGameOver: begin
        if (bus.start) begin
          p1_d        = 4'd0;
          p2_d        = 4'd0;
          game_over_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      p1_q        <= 4'd0;
      p2_q        <= 4'd0;
      cnt_q       <= 8'd0;
      serve_q     <= 1'b0;
      dir_q       <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      cnt_q       <= cnt_d;
      serve_q     <= serve_d;
      dir_q       <= dir_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.player1_score = p1_q;
  assign bus.player2_score = p2_q;
  assign bus.serve         = serve_q;
  assign bus.serve_dir     = dir_q;
  assign bus.playing       = playing_q;
  assign bus.game_over     = game_over_q;
  assign bus.winner        = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE = 5 and PAUSE_FRAMES = 3.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_score_keeper;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   serve_cnt = 0;
  int   saved_cnt;

  score_keeper_if bus ();

  score_keeper #(
    .WIN_SCORE   (5),
    .PAUSE_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.serve === 1'b1) serve_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  // Single-cycle miss pulses: 0 = miss_left, 1 = miss_right, 2 = both.
  task automatic pulse_miss(input int kind);
    bus.miss_left  = (kind != 1);
    bus.miss_right = (kind != 0);
    step();
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  task automatic full_point(input int kind);
    pulse_miss(kind);
    for (int i = 0; i < 3; i++) begin
      step();
      pulse_frame();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (bus.player1_score !== 4'd0) begin fails++; $display("FAIL reset_p1: got %0d want 0", bus.player1_score); end
    checks++; if (bus.player2_score !== 4'd0) begin fails++; $display("FAIL reset_p2: got %0d want 0", bus.player2_score); end
    checks++; if ({bus.serve, bus.serve_dir, bus.playing, bus.game_over, bus.winner} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000",
                        {bus.serve, bus.serve_dir, bus.playing, bus.game_over, bus.winner});
    end
  endtask

  task automatic test_start();
    step();
    checks++; if (bus.serve !== 1'b0) begin fails++; $display("FAIL idle_no_serve: got %0b want 0", bus.serve); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.serve !== 1'b1) begin fails++; $display("FAIL start_serve: got %0b want 1", bus.serve); end
    checks++; if (bus.playing !== 1'b1) begin fails++; $display("FAIL start_playing: got %0b want 1", bus.playing); end
    checks++; if (bus.serve_dir !== 1'b0) begin fails++; $display("FAIL start_dir: got %0b want 0", bus.serve_dir); end
    step();
    checks++; if (bus.serve !== 1'b0) begin fails++; $display("FAIL start_serve_one_cycle: got %0b want 0", bus.serve); end
  endtask

  task automatic test_point();
    pulse_miss(1);
    checks++; if (bus.player1_score !== 4'd1) begin fails++; $display("FAIL point_p1: got %0d want 1", bus.player1_score); end
    checks++; if (bus.playing !== 1'b0) begin fails++; $display("FAIL point_playing: got %0b want 0", bus.playing); end
    checks++; if (bus.serve_dir !== 1'b1) begin fails++; $display("FAIL point_dir: got %0b want 1", bus.serve_dir); end
    for (int i = 0; i < 2; i++) begin
      step();
      pulse_frame();
      checks++; if (bus.serve !== 1'b0) begin fails++; $display("FAIL point_early_serve%0d: got %0b want 0", i, bus.serve); end
    end
    step();
    pulse_frame();
    checks++; if (bus.serve !== 1'b1) begin fails++; $display("FAIL point_serve: got %0b want 1", bus.serve); end
    checks++; if (bus.playing !== 1'b1) begin fails++; $display("FAIL point_replay: got %0b want 1", bus.playing); end
    step();
    checks++; if (bus.serve !== 1'b0) begin fails++; $display("FAIL point_serve_one_cycle: got %0b want 0", bus.serve); end
  endtask

  task automatic test_ignored_in_pause();
    pulse_miss(0);
    checks++; if (bus.player2_score !== 4'd1) begin fails++; $display("FAIL left_p2: got %0d want 1", bus.player2_score); end
    checks++; if (bus.serve_dir !== 1'b0) begin fails++; $display("FAIL left_dir: got %0b want 0", bus.serve_dir); end
    pulse_miss(0);
    pulse_miss(1);
    pulse_miss(2);
    checks++; if ({bus.player1_score, bus.player2_score} !== {4'd1, 4'd1}) begin
      fails++; $display("FAIL pause_ignore: got %0d/%0d want 1/1", bus.player1_score, bus.player2_score);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      pulse_frame();
    end
    checks++; if (bus.serve !== 1'b1) begin fails++; $display("FAIL pause_resume_serve: got %0b want 1", bus.serve); end
    step();
  endtask

  task automatic test_double_miss();
    pulse_miss(2);
    checks++; if ({bus.player1_score, bus.player2_score} !== {4'd1, 4'd1}) begin
      fails++; $display("FAIL double_scores: got %0d/%0d want 1/1", bus.player1_score, bus.player2_score);
    end
    checks++; if (bus.playing !== 1'b0) begin fails++; $display("FAIL double_playing: got %0b want 0", bus.playing); end
    checks++; if (bus.serve_dir !== 1'b0) begin fails++; $display("FAIL double_dir: got %0b want 0", bus.serve_dir); end
    for (int i = 0; i < 2; i++) begin
      step();
      pulse_frame();
    end
    checks++; if (bus.serve !== 1'b0) begin fails++; $display("FAIL double_early_serve: got %0b want 0", bus.serve); end
    step();
    pulse_frame();
    checks++; if (bus.serve !== 1'b1) begin fails++; $display("FAIL double_serve: got %0b want 1", bus.serve); end
    step();
  endtask

  task automatic test_win();
    full_point(0);
    full_point(0);
    full_point(0);
    checks++; if (bus.player2_score !== 4'd4) begin fails++; $display("FAIL win_pre_p2: got %0d want 4", bus.player2_score); end
    pulse_miss(0);
    checks++; if (bus.player2_score !== 4'd5) begin fails++; $display("FAIL win_p2: got %0d want 5", bus.player2_score); end
    checks++; if (bus.game_over !== 1'b1) begin fails++; $display("FAIL win_game_over: got %0b want 1", bus.game_over); end
    checks++; if (bus.winner !== 1'b1) begin fails++; $display("FAIL win_winner: got %0b want 1", bus.winner); end
    checks++; if (bus.playing !== 1'b0) begin fails++; $display("FAIL win_playing: got %0b want 0", bus.playing); end
    saved_cnt = serve_cnt;
    pulse_miss(0);
    pulse_miss(1);
    for (int i = 0; i < 4; i++) pulse_frame();
    checks++; if ({bus.player1_score, bus.player2_score} !== {4'd1, 4'd5}) begin
      fails++; $display("FAIL over_frozen: got %0d/%0d want 1/5", bus.player1_score, bus.player2_score);
    end
    checks++; if ({bus.game_over, bus.winner} !== 2'b11) begin
      fails++; $display("FAIL over_status: got %b want 11", {bus.game_over, bus.winner});
    end
    checks++; if (serve_cnt !== saved_cnt) begin fails++; $display("FAIL over_no_serve: got %0d want %0d", serve_cnt, saved_cnt); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.player1_score, bus.player2_score} !== 8'd0) begin
      fails++; $display("FAIL restart_scores: got %0d/%0d want 0/0", bus.player1_score, bus.player2_score);
    end
    checks++; if (bus.game_over !== 1'b0) begin fails++; $display("FAIL restart_game_over: got %0b want 0", bus.game_over); end
    pulse_miss(0);
    pulse_miss(1);
    step();
    checks++; if ({bus.player1_score, bus.player2_score, bus.playing, bus.serve} !== 10'd0) begin
      fails++; $display("FAIL idle_ignore: got %0d/%0d playing %0b serve %0b want 0/0 0 0",
                        bus.player1_score, bus.player2_score, bus.playing, bus.serve);
    end
  endtask

  task automatic test_reset_mid_pause();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    full_point(1);
    full_point(0);
    full_point(1);
    full_point(0);
    pulse_miss(1);
    checks++; if ({bus.player1_score, bus.player2_score} !== {4'd3, 4'd2}) begin
      fails++; $display("FAIL pre_reset_scores: got %0d/%0d want 3/2", bus.player1_score, bus.player2_score);
    end
    step();
    pulse_frame();
    step();
    pulse_frame();
    saved_cnt = serve_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({bus.player1_score, bus.player2_score} !== 8'd0) begin
      fails++; $display("FAIL rst_scores: got %0d/%0d want 0/0", bus.player1_score, bus.player2_score);
    end
    checks++; if (bus.playing !== 1'b0) begin fails++; $display("FAIL rst_playing: got %0b want 0", bus.playing); end
    for (int i = 0; i < 5; i++) begin
      step();
      pulse_frame();
    end
    checks++; if (serve_cnt !== saved_cnt) begin fails++; $display("FAIL rst_no_serve: got %0d want %0d", serve_cnt, saved_cnt); end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    test_reset();
    test_start();
    test_point();
    test_ignored_in_pause();
    test_double_miss();
    test_win();
    test_reset_mid_pause();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Match-score state machine for pong. Sits directly upstream of the score-drawing stage and supplies its per-player digit values (0–9).
- Consumes miss pulses from the ball controller and a per-frame tick, then produces scores, serve requests and the game-over / winner status.
- Pure control block: no VGA timing passes through it.

Parameters:
- WIN_SCORE, 5: score at which a player wins. Legal range 1–9.
- PAUSE_FRAMES, 60: frame ticks to wait after a point before the next serve. Legal range 1–255.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame (vsync rising edge)
- start  in  1  level; request a new match
- miss_left  in  1  one-cycle pulse; ball passed the left paddle, so player 2 scores
- miss_right  in  1  one-cycle pulse; ball passed the right paddle, so player 1 scores
- player1_score  out  4  player 1 score, 0..WIN_SCORE
- player2_score  out  4  player 2 score, 0..WIN_SCORE
- serve  out  1  one-cycle pulse; ball controller launches the ball
- serve_dir  out  1  direction of the serve: 0 = towards player 1 (left), 1 = towards player 2 (right)
- playing  out  1  high while the ball is in play
- game_over  out  1  high in the GAME_OVER state
- winner  out  1  0 = player 1, 1 = player 2; valid only while game_over = 1

Behaviour:
- Clocking and reset:
  - Single clock domain. Every output is registered.
  - rst is synchronous and active-high; it takes priority over all other inputs.
  - Reset values: scores 0, serve 0, serve_dir 0, playing 0, game_over 0, winner 0, state IDLE, pause counter 0.
- IDLE:
  - Scores are held at 0.
  - start = 1 sampled on a cycle: the next cycle has serve = 1, serve_dir = 0, playing = 1, state PLAY.
- PLAY:
  - Misses are accepted only in this state; in all other states they are ignored.
  - On miss_right, player1_score increments on the next edge.
  - On miss_left, player2_score increments on the next edge.
  - playing drops in the same edge as the score update.
  - serve_dir is set towards the player who conceded: miss_right gives serve_dir = 1, miss_left gives serve_dir = 0.
  - If both misses occur in the same cycle: no score changes, playing drops, serve_dir is unchanged, and the block goes to POINT_PAUSE (replay).
- Win check:
  - Uses the incremented value in the same edge as the score update.
  - If that value equals WIN_SCORE: state GAME_OVER, game_over = 1, winner = scoring player.
  - Otherwise: state POINT_PAUSE with the pause counter cleared.
- POINT_PAUSE:
  - The pause counter increments on each frame_tick.
  - When a frame_tick arrives with counter = PAUSE_FRAMES-1: serve pulses for one cycle, playing = 1, counter clears, state PLAY.
  - Latency from miss to serve: exactly PAUSE_FRAMES frame ticks.
- GAME_OVER:
  - Scores are frozen.
  - start = 1 sampled: scores clear to 0, game_over = 0, state IDLE.
  - A start that is still held continues into IDLE, so a new match serves one cycle later. This is intended.
- Scores saturate at WIN_SCORE and never wrap; they are 4-bit and can never exceed 9.
- serve is high for exactly one cycle per serve, never two consecutive cycles.
- Reset mid-pause or mid-play forces the reset values on the next edge; a pending serve is cancelled.
- The frame_tick counter is 8 bits wide.

Test Plan:
- Reset then start = 1 for one cycle -> serve pulse one cycle later; playing = 1; serve_dir = 0; scores 0/0.
- In PLAY, miss_right pulse -> next cycle player1_score = 1, playing = 0, serve_dir = 1. With PAUSE_FRAMES = 3: serve pulses on the edge after the 3rd frame_tick, not earlier.
- WIN_SCORE = 5, player2 at 4, miss_left -> player2_score = 5, game_over = 1, winner = 1. Further misses and frame_ticks leave everything unchanged. start -> scores 0/0, game_over = 0.
- miss_left and miss_right in the same cycle -> scores unchanged, state POINT_PAUSE, serve follows after PAUSE_FRAMES ticks.
- Misses pulsed during POINT_PAUSE and during IDLE -> ignored; scores unchanged.
- rst asserted two frame ticks into POINT_PAUSE with score 3/2 -> next cycle scores 0/0, playing = 0, no serve pulse ever issued for that pause.
